// File: rtl/ctrl_pkg.sv
// Shared control encodings: FSM states, opcodes, ALU/mux selects and the strobe bundle.
// Also holds the opcode -> first-execute-state decode used by the controller.
package ctrl_pkg;

  localparam int CTRL_STATE_W = 5;

  typedef enum logic [CTRL_STATE_W-1:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEM_ADDR = 5'd2,
    S_MEM_RD   = 5'd3,
    S_MEM_WB   = 5'd4,
    S_MEM_WR   = 5'd5,
    S_R_EXEC   = 5'd6,
    S_R_WB     = 5'd7,
    S_BRANCH   = 5'd8,
    S_JUMP     = 5'd9,
    S_I_EXEC   = 5'd10,
    S_I_WB     = 5'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2, ALU_IMM = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_B = 2'd0, SRCB_FOUR = 2'd1, SRCB_SEXT = 2'd2, SRCB_SEXT_SH2 = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCSRC_ALU = 2'd0, PCSRC_ALUOUT = 2'd1, PCSRC_JUMP = 2'd2, PCSRC_RSVD = 2'd3
  } pc_source_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_t alu_src_b;
    alu_op_t    alu_op;
    pc_source_t pc_source;
  } ctrl_t;

  function automatic state_t decode_next(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:                nxt = S_R_EXEC;
      OP_LW, OP_SW:            nxt = S_MEM_ADDR;
      OP_BEQ:                  nxt = S_BRANCH;
      OP_J:                    nxt = S_JUMP;
      OP_ADDI, OP_ANDI, OP_ORI: nxt = S_I_EXEC;
      default:                 nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  function automatic logic is_legal_op(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational Moore decode of the FSM state into datapath strobes.
// Only FETCH looks at mem_ready; reset forces every strobe low.
module ctrl_outdec
  import ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  input  logic   i_rst,
  output ctrl_t  o_ctrl
);

  ctrl_t w_dec;

  // State to strobe table; anything not set stays 0.
  always_comb begin
    w_dec = '0;
    case (i_state)
      S_FETCH: begin
        w_dec.mem_read  = 1'b1;
        w_dec.alu_src_b = SRCB_FOUR;
        w_dec.ir_write  = i_mem_ready;
        w_dec.pc_write  = i_mem_ready;
      end
      S_DECODE:   w_dec.alu_src_b = SRCB_SEXT_SH2;
      S_MEM_ADDR: begin
        w_dec.alu_src_a = 1'b1;
        w_dec.alu_src_b = SRCB_SEXT;
      end
      S_MEM_RD: begin
        w_dec.mem_read = 1'b1;
        w_dec.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        w_dec.reg_write  = 1'b1;
        w_dec.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        w_dec.mem_write = 1'b1;
        w_dec.i_or_d    = 1'b1;
      end
      S_R_EXEC: begin
        w_dec.alu_src_a = 1'b1;
        w_dec.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        w_dec.reg_write = 1'b1;
        w_dec.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        w_dec.alu_src_a     = 1'b1;
        w_dec.alu_op        = ALU_SUB;
        w_dec.pc_write_cond = 1'b1;
        w_dec.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        w_dec.pc_write  = 1'b1;
        w_dec.pc_source = PCSRC_JUMP;
      end
      S_I_EXEC: begin
        w_dec.alu_src_a = 1'b1;
        w_dec.alu_src_b = SRCB_SEXT;
        w_dec.alu_op    = ALU_IMM;
      end
      S_I_WB:  w_dec.reg_write = 1'b1;
      default: w_dec = '0;
    endcase
  end

  assign o_ctrl = i_rst ? '0 : w_dec;

endmodule

// File: rtl/control_fsm.sv
// Multicycle controller: state register, next-state logic and retired-instruction counter.
// Strobes come from ctrl_outdec; illegal_op flags an unknown opcode during DECODE.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter int STATE_W  = 5,
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_source,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired,
  output logic [STATE_W-1:0]  State
);

  localparam logic [RETIRE_W-1:0] RET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [RETIRE_W-1:0] r_retired;
  ctrl_t               w_ctrl;

  // State sequencing; every completed instruction bumps the counter on its way back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE:   r_state <= decode_next(opcode);
        S_MEM_ADDR: begin
          if (opcode == OP_LW)      r_state <= S_MEM_RD;
          else if (opcode == OP_SW) r_state <= S_MEM_WR;
          else                      r_state <= S_FETCH;
        end
        S_MEM_RD:   if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WR: begin
          if (mem_ready) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + RET_ONE;
          end
        end
        S_R_EXEC:   r_state <= S_R_WB;
        S_I_EXEC:   r_state <= S_I_WB;
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + RET_ONE;
        end
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .i_rst       (rst),
    .o_ctrl      (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;

  assign illegal_op = !rst && (r_state == S_DECODE) && !is_legal_op(opcode);
  assign retired    = r_retired;
  assign State      = STATE_W'(r_state);

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm (RETIRE_W=4 so the retired counter wrap is reachable).
// Each cycle pushes the expected {State, strobes, illegal_op, retired} and compares it at negedge.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] retired;
  logic [4:0] State;

  int errors = 0;
  int checks = 0;
  logic [3:0]  m_ret = 4'd0;
  logic [25:0] sb_q[$];

  always #5 clk = ~clk;

  control_fsm #(.STATE_W(5), .RETIRE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .retired(retired), .State(State)
  );

  // Strobe layout: pw pwc iod mrd mw irw m2r rd rw sa _ srcb _ aluop _ pcsrc
  function automatic logic [15:0] exp_strb(input logic [4:0] st, input logic mr, input logic r);
    logic [15:0] v;
    case (st)
      5'd0:    v = {mr, 3'b001, 1'b0, mr, 4'b0000, 6'b010000};
      5'd1:    v = 16'b0000000000_11_00_00;
      5'd2:    v = 16'b0000000001_10_00_00;
      5'd3:    v = 16'b0011000000_00_00_00;
      5'd4:    v = 16'b0000001010_00_00_00;
      5'd5:    v = 16'b0010100000_00_00_00;
      5'd6:    v = 16'b0000000001_00_10_00;
      5'd7:    v = 16'b0000000110_00_00_00;
      5'd8:    v = 16'b0100000001_00_01_01;
      5'd9:    v = 16'b1000000000_00_00_10;
      5'd10:   v = 16'b0000000001_10_11_00;
      5'd11:   v = 16'b0000000010_00_00_00;
      default: v = 16'b0;
    endcase
    return r ? 16'b0 : v;
  endfunction

  function automatic logic [25:0] obs();
    return {State, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
            illegal_op, retired};
  endfunction

  task automatic drive_push(input logic r, input logic mr, input logic [5:0] op,
                            input logic [4:0] st, input logic ill, input logic [3:0] ret);
    rst       = r;
    mem_ready = mr;
    opcode    = op;
    sb_q.push_back({st, exp_strb(st, mr, r), ill & ~r, ret});
  endtask

  task automatic test_reset();
    logic [25:0] e;
    repeat (3) @(posedge clk);
    #1;
    drive_push(1'b1, 1'b1, 6'h00, 5'd0, 1'b0, 4'd0);
    @(negedge clk);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs(), e); end
    @(posedge clk); #1;
    drive_push(1'b0, 1'b0, 6'h00, 5'd0, 1'b0, 4'd0);
    @(negedge clk);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs(), e); end
  endtask

  task automatic test_lw();
    logic [25:0] e;
    logic [4:0] seq[6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd0};
    logic       mr[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 5) m_ret = m_ret + 4'd1;
      drive_push(1'b0, mr[i], 6'h23, seq[i], 1'b0, m_ret);
      @(negedge clk);
      e = sb_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL lw cyc%0d got=%h exp=%h", i, obs(), e); end
    end
  endtask

  task automatic test_sw_stall();
    logic [25:0] e;
    logic [4:0] seq[7] = '{5'd0, 5'd1, 5'd2, 5'd5, 5'd5, 5'd5, 5'd0};
    logic       mr[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i == 6) m_ret = m_ret + 4'd1;
      drive_push(1'b0, mr[i], 6'h2B, seq[i], 1'b0, m_ret);
      @(negedge clk);
      e = sb_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL sw cyc%0d got=%h exp=%h", i, obs(), e); end
    end
  endtask

  task automatic test_illegal();
    logic [25:0] e;
    logic [4:0] seq[3] = '{5'd0, 5'd1, 5'd0};
    logic       mr[3]  = '{1'b1, 1'b1, 1'b0};
    logic       ill[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive_push(1'b0, mr[i], 6'h3F, seq[i], ill[i], m_ret);
      @(negedge clk);
      e = sb_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, obs(), e); end
    end
  endtask

  task automatic test_alu_ops();
    logic [25:0] e;
    logic [5:0] ops[5]     = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h04};
    int         lens[5]    = '{5, 5, 5, 5, 4};
    logic [4:0] seqs[5][5] = '{'{5'd0, 5'd1, 5'd6, 5'd7, 5'd0},
                               '{5'd0, 5'd1, 5'd10, 5'd11, 5'd0},
                               '{5'd0, 5'd1, 5'd10, 5'd11, 5'd0},
                               '{5'd0, 5'd1, 5'd10, 5'd11, 5'd0},
                               '{5'd0, 5'd1, 5'd8, 5'd0, 5'd0}};
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < lens[n]; i++) begin
        @(posedge clk); #1;
        if (i == lens[n] - 1) m_ret = m_ret + 4'd1;
        drive_push(1'b0, (i != lens[n] - 1), ops[n], seqs[n][i], 1'b0, m_ret);
        @(negedge clk);
        e = sb_q.pop_front(); checks++;
        if (obs() !== e) begin
          errors++; $display("FAIL alu op=%h cyc%0d got=%h exp=%h", ops[n], i, obs(), e);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [25:0] e;
    logic [4:0] seq[5] = '{5'd0, 5'd1, 5'd6, 5'd0, 5'd0};
    logic       rs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       mr[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive_push(rs[i], mr[i], 6'h00, seq[i], 1'b0, (i >= 3) ? 4'd0 : m_ret);
      @(negedge clk);
      e = sb_q.pop_front(); checks++;
      if (obs() !== e) begin errors++; $display("FAIL rst_mid cyc%0d got=%h exp=%h", i, obs(), e); end
    end
    m_ret = 4'd0;
  endtask

  task automatic test_back_to_back();
    logic [25:0] e;
    logic [4:0] st;
    for (int n = 0; n < 17; n++) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (k == 0 && n > 0) m_ret = m_ret + 4'd1;
        st = (k == 0) ? 5'd0 : ((k == 1) ? 5'd1 : 5'd9);
        drive_push(1'b0, 1'b1, 6'h02, st, 1'b0, m_ret);
        @(negedge clk);
        e = sb_q.pop_front(); checks++;
        if (obs() !== e) begin
          errors++; $display("FAIL jump n%0d k%0d got=%h exp=%h", n, k, obs(), e);
        end
      end
    end
    @(posedge clk); #1;
    m_ret = m_ret + 4'd1;
    drive_push(1'b0, 1'b0, 6'h02, 5'd0, 1'b0, m_ret);
    @(negedge clk);
    e = sb_q.pop_front(); checks++;
    if (obs() !== e) begin errors++; $display("FAIL jump_end got=%h exp=%h", obs(), e); end
    checks++;
    if (retired !== 4'd1) begin errors++; $display("FAIL jump_wrap got=%0d exp=1", retired); end
  endtask

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    opcode    = 6'h00;
    test_reset();
    test_lw();
    test_sw_stall();
    test_illegal();
    test_alu_ops();
    test_rst_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
